// File: rtl/seq_addsub_cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder/subtractor.
package seq_addsub_cla_pkg;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;
    localparam int   SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: flat lookahead carries plus group P/G.
module cla4_slice
    import seq_addsub_cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic [SLICE_W-1:0] c,
    output logic               P,
    output logic               G
);

    logic [SLICE_W-1:0] p_s;
    logic [SLICE_W-1:0] g_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Every carry is a two-level sum of products of cin and the bit P/G terms.
    assign c[0] = g_s[0] | (p_s[0] & cin);
    assign c[1] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c[2] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c[3] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ {c[2:0], cin};
    assign P = &p_s;
    assign G = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

endmodule

// File: rtl/seq_addsub_cla.sv
// Multi-cycle adder/subtractor reusing one 4-bit CLA slice, LSB nibble first,
// with word-level augmented P/G for wider lookahead consumers.
module seq_addsub_cla
    import seq_addsub_cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             P,
    output logic             G
);

    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   a_r, a_nxt_s, b_r, b_nxt_s, s_r, s_nxt_s;
    logic [IDXW-1:0]    idx_r, idx_nxt_s;
    logic               carry_r, carry_nxt_s, pacc_r, pacc_nxt_s, gacc_r, gacc_nxt_s;
    logic               busy_r, busy_nxt_s, done_r, done_nxt_s, cout_r, cout_nxt_s;
    logic               ovf_r, ovf_nxt_s, zero_r, zero_nxt_s, p_r, p_nxt_s, g_r, g_nxt_s;
    logic [IDXW+1:0]    base_s;
    logic [SLICE_W-1:0] slice_s, slice_c;
    logic               slice_p, slice_g;
    logic               unused_carry_s;

    assign base_s         = {idx_r, 2'b00};
    assign unused_carry_s = ^slice_c[1:0];

    cla4_slice u_slice (
        .a   (a_r[base_s +: SLICE_W]),
        .b   (b_r[base_s +: SLICE_W]),
        .cin (carry_r),
        .s   (slice_s),
        .c   (slice_c),
        .P   (slice_p),
        .G   (slice_g)
    );

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        s_nxt_s     = s_r;
        idx_nxt_s   = idx_r;
        carry_nxt_s = carry_r;
        pacc_nxt_s  = pacc_r;
        gacc_nxt_s  = gacc_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        cout_nxt_s  = cout_r;
        ovf_nxt_s   = ovf_r;
        zero_nxt_s  = zero_r;
        p_nxt_s     = p_r;
        g_nxt_s     = g_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    a_nxt_s     = a;
                    b_nxt_s     = (op == OP_SUB) ? ~b : b;
                    carry_nxt_s = (op == OP_ADD) ? cin : 1'b1;
                    idx_nxt_s   = {IDXW{1'b0}};
                    pacc_nxt_s  = 1'b1;
                    gacc_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                s_nxt_s[base_s +: SLICE_W] = slice_s;
                carry_nxt_s = slice_c[SLICE_W-1];
                pacc_nxt_s  = pacc_r & slice_p;
                gacc_nxt_s  = slice_g | (slice_p & gacc_r);
                idx_nxt_s   = idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                // The top nibble's c[2] is the carry into the sign bit.
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = DONE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    cout_nxt_s  = slice_c[SLICE_W-1];
                    ovf_nxt_s   = slice_c[SLICE_W-2] ^ slice_c[SLICE_W-1];
                    zero_nxt_s  = (s_nxt_s == {WIDTH{1'b0}});
                    p_nxt_s     = pacc_nxt_s;
                    g_nxt_s     = gacc_nxt_s;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            idx_r   <= {IDXW{1'b0}};
            carry_r <= 1'b0;
            pacc_r  <= 1'b1;
            gacc_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b1;
            p_r     <= 1'b0;
            g_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            s_r     <= s_nxt_s;
            idx_r   <= idx_nxt_s;
            carry_r <= carry_nxt_s;
            pacc_r  <= pacc_nxt_s;
            gacc_r  <= gacc_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            cout_r  <= cout_nxt_s;
            ovf_r   <= ovf_nxt_s;
            zero_r  <= zero_nxt_s;
            p_r     <= p_nxt_s;
            g_r     <= g_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;
    assign P    = p_r;
    assign G    = g_r;

endmodule

// File: tb/tb_seq_addsub_cla.sv
// Self-checking bench for seq_addsub_cla (WIDTH=16): directed scenarios plus
// random operations against a plain-arithmetic reference model.
module tb_seq_addsub_cla;

    logic        clk = 1'b0;
    logic        rst_n, start, op, cin;
    logic [15:0] a, b, s;
    logic        busy, done, cout, ovf, zero, P, G;
    int          errors = 0;
    int          checks = 0;

    seq_addsub_cla #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero), .P(P), .G(G)
    );

    always #5 clk = ~clk;

    // Reference: {s, cout, ovf, zero, P, G} from integer arithmetic.
    function automatic logic [20:0] model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [15:0] be;
        logic [16:0] sum, gen;
        logic        c0, ov;
        be  = o ? ~y : y;
        c0  = o ? 1'b1 : ci;
        sum = {1'b0, x} + {1'b0, be} + {16'd0, c0};
        gen = {1'b0, x} + {1'b0, be};
        if (o) ov = (x[15] != y[15]) && (sum[15] != x[15]);
        else   ov = (x[15] == y[15]) && (sum[15] != x[15]);
        return {sum[15:0], sum[16], ov, (sum[15:0] == 16'd0), ((x ^ be) == 16'hFFFF), gen[16]};
    endfunction

    function automatic logic [20:0] observed();
        return {s, cout, ovf, zero, P, G};
    endfunction

    // Issue one operation, scramble inputs after acceptance, wait for done.
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci,
                         output int edges, output int bcyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = ci;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); cin = 1'($urandom);
        edges = 0;
        bcyc  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (busy === 1'b1) bcyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; cin = 1'b0; a = 16'd0; b = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, s, cout, ovf, zero, P, G} !== {2'b00, 16'h0000, 5'b00100}) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b s=%h cout=%b ovf=%b zero=%b P=%b G=%b",
                     busy, done, s, cout, ovf, zero, P, G);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int e, bc;
        do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, e, bc);
        checks++;
        if ({s, cout, ovf, zero} !== {16'h0100, 3'b000}) begin
            errors++;
            $display("FAIL add_00ff: got s=%h cout=%b ovf=%b zero=%b want 0100 0 0 0", s, cout, ovf, zero);
        end
        checks++;
        if (e !== 4 || bc !== 4) begin
            errors++;
            $display("FAIL add_latency: got edges=%0d busy_cycles=%0d want 4 4", e, bc);
        end
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, e, bc);
        checks++;
        if ({s, cout, zero, P, G} !== {16'h0000, 4'b1101}) begin
            errors++;
            $display("FAIL add_wrap: got s=%h cout=%b zero=%b P=%b G=%b want 0000 1 1 0 1", s, cout, zero, P, G);
        end
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, e, bc);
        checks++;
        if ({s, ovf, cout} !== {16'h8000, 2'b10}) begin
            errors++;
            $display("FAIL add_ovf: got s=%h ovf=%b cout=%b want 8000 1 0", s, ovf, cout);
        end
    endtask

    task automatic test_sub();
        int e, bc;
        do_op(1'b1, 16'h0005, 16'h0007, 1'b0, e, bc);
        checks++;
        if ({s, cout, ovf} !== {16'hFFFE, 2'b00}) begin
            errors++;
            $display("FAIL sub_borrow: got s=%h cout=%b ovf=%b want fffe 0 0", s, cout, ovf);
        end
        do_op(1'b1, 16'h8000, 16'h0001, 1'b1, e, bc);
        checks++;
        if ({s, cout, ovf} !== {16'h7FFF, 2'b11}) begin
            errors++;
            $display("FAIL sub_ovf: got s=%h cout=%b ovf=%b want 7fff 1 1", s, cout, ovf);
        end
        checks++;
        if (observed() !== model(1'b1, 16'h8000, 16'h0001, 1'b1)) begin
            errors++;
            $display("FAIL sub_model: got %h want %h", observed(), model(1'b1, 16'h8000, 16'h0001, 1'b1));
        end
    endtask

    task automatic test_ignore_start();
        int          dones = 0;
        logic [20:0] got = 21'd0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                got = observed();
            end
        end
        checks++;
        if (dones !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_dones: got dones=%0d busy=%b want 1 0", dones, busy);
        end
        checks++;
        if (got[20:5] !== 16'h2346 || got[4] !== 1'b0 || got !== model(1'b0, 16'h1234, 16'h1111, 1'b1)) begin
            errors++;
            $display("FAIL ignore_start_result: got %h want %h", got, model(1'b0, 16'h1234, 16'h1111, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        do_op(1'b0, 16'h0100, 16'h0200, 1'b0, e, bc);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h000A; b = 16'h0005; cin = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy, done);
        end
        e = 0;
        while (done !== 1'b1 && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        checks++;
        if (e !== 4 || s !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_result: got edges=%0d s=%h want 4 000f", e, s);
        end
    endtask

    task automatic test_reset_mid_run();
        int e, bc;
        int dones = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, s, cout, ovf, zero, P, G} !== {2'b00, 16'h0000, 5'b00100}) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b s=%h cout=%b ovf=%b zero=%b P=%b G=%b",
                     busy, done, s, cout, ovf, zero, P, G);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got dones=%0d want 0", dones);
        end
        do_op(1'b0, 16'h0003, 16'h0004, 1'b0, e, bc);
        checks++;
        if (s !== 16'h0007 || e !== 4) begin
            errors++;
            $display("FAIL reset_recover: got s=%h edges=%0d want 0007 4", s, e);
        end
    endtask

    task automatic test_random();
        int          e, bc;
        logic        o, ci;
        logic [15:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o  = 1'($urandom);
            ci = 1'($urandom);
            x  = 16'($urandom);
            y  = (i % 8 == 0) ? ~x : 16'($urandom);
            do_op(o, x, y, ci, e, bc);
            checks++;
            if (observed() !== model(o, x, y, ci) || e !== 4) begin
                errors++;
                $display("FAIL random_%0d: op=%b a=%h b=%h cin=%b got %h edges=%0d want %h edges=4",
                         i, o, x, y, ci, observed(), e, model(o, x, y, ci));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_addsub_cla.md
Name: seq_addsub_cla

Overview:
- Multi-cycle WIDTH-bit adder/subtractor. One 4-bit carry-lookahead slice is reused, one nibble per clock, LSB nibble first.
- Subtraction is the reverse operation of the slice adder and is computed as a + ~b + 1.
- The unit exports word-level augmented P/G so that wider lookahead logic can consume them.
- It sits beside the combinational CLA datapath as the area-lean, handshaked arithmetic unit.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived; number of slice iterations per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request; accepted only when busy=0
- op  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when op=1
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when the result is valid
- s  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  s == 0
- P  output  1  word group propagate
- G  output  1  word group generate

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, s, cout, ovf, P, G = 0; zero=1.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1: capture the operands.
  - a_r=a; b_r = op ? ~b : b; carry_r = op ? 1 : cin.
  - idx=0, Pacc=1, Gacc=0, state→RUN, busy=1.
- RUN, each edge:
  - Slice inputs: a_r[4idx+:4], b_r[4idx+:4], carry_r.
  - s[4idx+:4] ← slice sum; carry_r ← slice c[3].
  - Pacc ← Pacc & Ps.
  - Gacc ← Gs | (Ps & Gacc), where Ps/Gs are the slice P/G.
  - idx++.
  - On the idx==NIB-1 edge:
    - state→DONE, busy=0, done=1.
    - cout ← final carry.
    - ovf ← (carry into bit WIDTH-1) ^ cout, using slice c[2] of the last nibble.
    - zero, P, G updated from the full result.
- DONE lasts one cycle: done=1, then →IDLE and done=0, unless start is asserted (back-to-back).
- Latency: start accepted at edge t0; done is high in the cycle after edge tNIB (NIB+1 edges total). For WIDTH=16, done rises at edge t4.
- Throughput: one operation every NIB+1 cycles.
- start while busy=1 is ignored, with no queueing.
- Operand, op and cin changes after acceptance have no effect.
- s bits are overwritten nibble by nibble during RUN. s is only valid while done=1 and afterwards until the next accepted start.
- P/G depend on the effective operands (b inverted for sub). They are independent of cin, per the augmented-CLA definition.
- rst_n low at any time, including mid-RUN, immediately forces the reset values and aborts the operation. The first start after release is handled normally.

Decomposition:
- Shared package: op encoding constants OP_ADD=0, OP_SUB=1; FSM state typedef {IDLE, RUN, DONE}; SLICE_W=4.
- Sub-module cla4_slice (purely combinational).
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], c[3:0] (internal carries, c[3] = carry out), P, G.
  - Carry-lookahead equations only; no ripple.
- Top: FSM, nibble index counter, operand/carry registers, P/G accumulators, flags.

Test Plan (WIDTH=16):
1. Add 0x00FF + 0x0001, cin=0 → s=0x0100, cout=0, ovf=0, zero=0; done at the 4th edge after the start edge; busy high for exactly 4 cycles.
2. Add 0xFFFF + 0x0001, cin=0 → s=0x0000, cout=1, zero=1, P=0, G=1. Then 0x7FFF + 0x0001 → s=0x8000, ovf=1, cout=0.
3. Sub 0x0005 − 0x0007 → s=0xFFFE, cout=0, ovf=0. Then sub 0x8000 − 0x0001 → s=0x7FFF, cout=1, ovf=1.
4. Add 0x1234 + 0x1111 with cin=1. Mid-RUN, pulse start with a=0xFFFF, b=0xFFFF and change op to 1 → s=0x2346 unaffected, cout=0; the second start is ignored (no extra done).
5. Back-to-back: start held during the DONE cycle with 0x000A + 0x0005 → second result s=0x000F, done again 4 edges later; no idle gap.
6. Drop rst_n at the 2nd RUN edge → busy/done/s/cout/ovf/P/G go to 0 and zero to 1 immediately, with no later done pulse. After release, add 0x0003 + 0x0004 → s=0x0007.
